// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation,
// used by both the read-side and write-side pointer handlers.
package fifo_pkg;

  localparam int MAX_PTR_W = 16;

  // Narrower pointers are zero-extended, which leaves the conversion unchanged.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int depth_of(input int ptr_w);
    return 32'sd1 << ptr_w;
  endfunction

endpackage

// File: rtl/fifo_rd_port_chk.sv
// Runtime invariants of the FIFO read port.
module fifo_rd_port_chk #(
  parameter int PTR_WIDTH = 3,
  parameter int DEPTH     = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic [PTR_WIDTH:0] g_wptr_s_i,
  input logic [PTR_WIDTH:0] rcount_i,
  input logic               issue_i,
  input logic               empty_i
);

  localparam int PW1 = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] g_prev_q;

  // Track the previous synchronized pointer and check invariants each edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      g_prev_q <= {PW1{1'b0}};
    end else begin
      g_prev_q <= g_wptr_s_i;
      assert ($countones(g_wptr_s_i ^ g_prev_q) <= 1);
      assert (rcount_i <= PW1'(DEPTH));
      assert (!(issue_i && empty_i));
    end
  end

endmodule

// File: rtl/ptr_sync.sv
// N-stage flop synchronizer for a Gray pointer crossing clock domains.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift chain: stage 0 samples the foreign-domain pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_port.sv
// Read-domain side of the async FIFO: write-pointer sync, read pointer,
// RAM read issue and a two-entry first-word-fall-through output stage.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                  i_Rclk,
  input  logic                  i_Rrst_n,
  input  logic [PTR_WIDTH:0]    i_g_wptr,
  output logic [PTR_WIDTH:0]    o_g_rptr,
  output logic                  o_ren,
  output logic [PTR_WIDTH-1:0]  o_raddr,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [PTR_WIDTH:0]    o_rcount
);

  localparam int PW1   = PTR_WIDTH + 1;
  localparam int DEPTH = depth_of(PTR_WIDTH);

  logic [PTR_WIDTH:0]    g_wptr_s, b_wptr_s, rcount_s, b_rptr_inc_s;
  logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d, g_rptr_q, g_rptr_d;
  logic                  inflight_q, inflight_d, valid_q, valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, skid_q, skid_d;
  logic [1:0]            occ_s;
  logic                  empty_s, pop_s, issue_s;

  ptr_sync #(
    .WIDTH  (PW1),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk_i  (i_Rclk),
    .rst_ni (i_Rrst_n),
    .d_i    (i_g_wptr),
    .q_o    (g_wptr_s)
  );

  // Occupancy and issue decision; a pop frees a slot in the same cycle.
  always_comb begin
    b_wptr_s     = PW1'(gray2bin(MAX_PTR_W'(g_wptr_s)));
    b_rptr_inc_s = b_rptr_q + PW1'(1);
    rcount_s     = b_wptr_s - b_rptr_q;
    empty_s      = (g_wptr_s == g_rptr_q);
    pop_s        = valid_q & i_ready;
    occ_s        = {1'b0, valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q};
    issue_s      = ~empty_s & ((occ_s - {1'b0, pop_s}) < 2'd2);
  end

  // Pointer advance and output-stage steering; the output register always holds the oldest word.
  always_comb begin
    b_rptr_d     = b_rptr_q;
    g_rptr_d     = g_rptr_q;
    inflight_d   = issue_s;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    data_d       = data_q;
    skid_d       = skid_q;
    if (issue_s) begin
      b_rptr_d = b_rptr_inc_s;
      g_rptr_d = PW1'(bin2gray(MAX_PTR_W'(b_rptr_inc_s)));
    end else begin
      b_rptr_d = b_rptr_q;
      g_rptr_d = g_rptr_q;
    end
    if (inflight_q) begin
      if ((!valid_q || pop_s) && !skid_valid_q) begin
        data_d  = i_rdata;
        valid_d = 1'b1;
      end else if (pop_s) begin
        data_d       = skid_q;
        skid_d       = i_rdata;
        skid_valid_d = 1'b1;
      end else begin
        skid_d       = i_rdata;
        skid_valid_d = 1'b1;
      end
    end else if (pop_s) begin
      if (skid_valid_q) begin
        data_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      b_rptr_q     <= {PW1{1'b0}};
      g_rptr_q     <= {PW1{1'b0}};
      inflight_q   <= 1'b0;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      skid_q       <= {DATA_WIDTH{1'b0}};
    end else begin
      b_rptr_q     <= b_rptr_d;
      g_rptr_q     <= g_rptr_d;
      inflight_q   <= inflight_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
      data_q       <= data_d;
      skid_q       <= skid_d;
    end
  end

  assign o_g_rptr       = g_rptr_q;
  assign o_ren          = issue_s;
  assign o_raddr        = b_rptr_q[PTR_WIDTH-1:0];
  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_empty        = empty_s;
  assign o_almost_empty = (rcount_s <= PW1'(AE_THRESH));
  assign o_rcount       = rcount_s;

  fifo_rd_port_chk #(
    .PTR_WIDTH (PTR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_chk (
    .clk_i      (i_Rclk),
    .rst_ni     (i_Rrst_n),
    .g_wptr_s_i (g_wptr_s),
    .rcount_i   (rcount_s),
    .issue_i    (issue_s),
    .empty_i    (empty_s)
  );

endmodule

// File: tb/tb_fifo_rd_port.sv
// Scoreboard bench for fifo_rd_port: directed write-pointer vectors, a 1-cycle RAM model
// and a negedge monitor that compares every popped word against the expected queue.
module tb_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] g_wptr = 4'd0;
  logic [3:0] g_rptr, rcount;
  logic       ren, valid, ready = 1'b0, empty, ae;
  logic [2:0] raddr;
  logic [7:0] rdata = 8'd0, data;
  logic [7:0] ram [8];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  int raddr_log [$];
  int ren_cnt = 0;
  int valid_seen = 0;
  int wbin = 0;

  always #5 clk = ~clk;

  fifo_rd_port dut (
    .i_Rclk         (clk),
    .i_Rrst_n       (rst_n),
    .i_g_wptr       (g_wptr),
    .o_g_rptr       (g_rptr),
    .o_ren          (ren),
    .o_raddr        (raddr),
    .i_rdata        (rdata),
    .o_data         (data),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_empty        (empty),
    .o_almost_empty (ae),
    .o_rcount       (rcount)
  );

  always @(posedge clk) begin
    if (ren) rdata <= ram[raddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold under back-pressure.
  initial begin
    logic       hold_pend;
    logic [7:0] held;
    hold_pend = 1'b0;
    held = 8'd0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ren) begin
          ren_cnt++;
          raddr_log.push_back(int'(raddr));
        end
        if (valid) valid_seen++;
        if (hold_pend && valid) chk("hold", data, held);
        if (valid && ready) begin
          if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
          else chk("pop_data", data, exp_q.pop_front());
        end
        hold_pend = valid && !ready;
        held = data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  // Advance the write pointer one count per cycle, as the real writer does.
  task automatic step_wptr(input int to);
    while (wbin != to) begin
      @(posedge clk); #1;
      wbin = (wbin + 1) % 16;
      g_wptr = to_gray(wbin);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    g_wptr = 4'd0;
    wbin = 0;
    ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || valid) && k < max) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 8'd0;
    repeat (2) @(posedge clk);

    // 1: asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_ren", ren, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", ae, 1);
    chk("rst_g_rptr", g_rptr, 4'b0000);
    chk("rst_rcount", rcount, 0);
    chk("rst_data", data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // 2: single word
    ram[0] = 8'hA5;
    exp_q.push_back(8'hA5);
    ready = 1'b1;
    wbin = 1;
    g_wptr = 4'b0001;
    @(posedge clk); #1;
    chk("single_ren_c2", ren, 0);
    @(posedge clk); #1;
    chk("single_ren_c3", ren, 1);
    chk("single_raddr", raddr, 0);
    chk("single_rcount", rcount, 1);
    wait_idle(10);
    chk("single_g_rptr", g_rptr, 4'b0001);
    chk("single_empty", empty, 1);
    chk("single_valid", valid, 0);

    // 3: back-pressure with a full RAM
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ram[i] = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
    end
    ren_cnt = 0;
    raddr_log.delete();
    step_wptr(8);
    chk("bp_wptr", g_wptr, 4'b1100);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_ren_count", ren_cnt, 2);
    chk("bp_valid", valid, 1);
    chk("bp_data", data, 8'h10);
    chk("bp_rcount", rcount, 6);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_burst_left", exp_q.size(), 0);
    chk("bp_burst_valid", valid, 0);
    chk("bp_rcount_end", rcount, 0);
    chk("bp_empty_end", empty, 1);

    // 4: wrap, 4 more words after draining 8
    for (int i = 0; i < 4; i++) begin
      ram[i] = 8'h20 + 8'(i);
      exp_q.push_back(8'h20 + 8'(i));
    end
    step_wptr(12);
    wait_idle(30);
    chk("wrap_nreads", raddr_log.size(), 12);
    if (raddr_log.size() == 12) begin
      for (int i = 0; i < 12; i++) chk("wrap_raddr", raddr_log[i], i % 8);
    end
    chk("wrap_g_rptr", g_rptr, 4'b1010);
    chk("wrap_rcount", rcount, 0);

    // 5: almost-empty threshold
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ram[i] = 8'h30 + 8'(i);
      exp_q.push_back(8'h30 + 8'(i));
    end
    step_wptr(5);
    repeat (4) @(posedge clk);
    #1;
    chk("ae_rcount3", rcount, 3);
    chk("ae_deasserted", ae, 0);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    chk("ae_rcount2", rcount, 2);
    chk("ae_asserted", ae, 1);
    ready = 1'b1;
    wait_idle(20);

    // 6: reset mid-burst
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ram[i] = 8'h40 + 8'(i);
      exp_q.push_back(8'h40 + 8'(i));
    end
    step_wptr(8);
    repeat (4) @(posedge clk);
    #1 ready = 1'b1;
    #1;
    chk("mid_valid_pre", valid, 1);
    chk("mid_ren_pre", ren, 1);
    rst_n = 1'b0;
    exp_q.delete();
    g_wptr = 4'd0;
    wbin = 0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ren", ren, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ae", ae, 1);
    chk("mid_rst_g_rptr", g_rptr, 4'b0000);
    chk("mid_rst_rcount", rcount, 0);
    chk("mid_rst_data", data, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    ren_cnt = 0;
    valid_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_ren", ren_cnt, 0);
    chk("post_rst_valid", valid_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
